// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared SAD engine types and default sizes
package sad_pkg;

  localparam int N_PIX_DEFAULT  = 256;
  localparam int PIX_W_DEFAULT  = 8;
  localparam int ADDR_W_DEFAULT = $clog2(N_PIX_DEFAULT);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_FILL = 2'd1,
    L_KICK = 2'd2,
    L_WAIT = 2'd3
  } load_state_t;

endpackage

// File: rtl/sad_beat_counter.sv
// rtl/sad_beat_counter.sv - beat index counter that saturates at the last pixel
module sad_beat_counter #(
  parameter int N_PIX = 256,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LAST_IDX = W'(N_PIX - 1);

  assign last = (count == LAST_IDX);

  // Holding at the last index keeps the address from wrapping into pixel 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sad_block_loader.sv
// rtl/sad_block_loader.sv - streams A/B pixel pairs into block memories and kicks the SAD controller
module sad_block_loader
  import sad_pkg::*;
#(
  parameter int N_PIX  = N_PIX_DEFAULT,
  parameter int PIX_W  = PIX_W_DEFAULT,
  parameter int ADDR_W = $clog2(N_PIX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic                 load_abort,
  input  logic                 s_valid,
  input  logic [2*PIX_W-1:0]   s_data,
  output logic                 s_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [PIX_W-1:0]     mem_a_wdata,
  output logic [PIX_W-1:0]     mem_b_wdata,
  output logic                 go,
  input  logic                 sad_done,
  output logic                 busy,
  output logic                 load_done
);

  load_state_t       state;
  logic [ADDR_W-1:0] count;
  logic              last;
  logic              accept;

  // Abort wins over a coincident beat by withdrawing ready.
  assign s_ready = (state == L_FILL) && !load_abort;
  assign accept  = s_valid && s_ready;
  assign go      = (state == L_KICK);
  assign busy    = (state != L_IDLE);

  sad_beat_counter #(
    .N_PIX (N_PIX),
    .W     (ADDR_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear ((state == L_IDLE) && load_req),
    .inc   (accept),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= L_IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_a_wdata <= '0;
      mem_b_wdata <= '0;
      load_done   <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        L_IDLE: begin
          if (load_req) state <= L_FILL;
        end
        L_FILL: begin
          if (load_abort) begin
            state <= L_IDLE;
          end else if (accept) begin
            mem_we      <= 1'b1;
            mem_addr    <= count;
            mem_a_wdata <= s_data[PIX_W-1:0];
            mem_b_wdata <= s_data[2*PIX_W-1:PIX_W];
            if (last) state <= L_KICK;
          end
        end
        // The final write sits on the bus during the kick cycle.
        L_KICK: begin
          state <= L_WAIT;
        end
        L_WAIT: begin
          if (sad_done) begin
            state     <= L_IDLE;
            load_done <= 1'b1;
          end
        end
        default: state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_block_loader.sv
// tb/tb_sad_block_loader.sv - randomized self-checking bench for sad_block_loader
module tb_sad_block_loader;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst, load_req, load_abort, s_valid, sad_done;
  logic [15:0] s_data;
  logic        s_ready, mem_we, go, busy, load_done;
  logic [7:0]  mem_addr, mem_a_wdata, mem_b_wdata;

  sad_block_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_req    (load_req),
    .load_abort  (load_abort),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_a_wdata (mem_a_wdata),
    .mem_b_wdata (mem_b_wdata),
    .go          (go),
    .sad_done    (sad_done),
    .busy        (busy),
    .load_done   (load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int a;
    int b;
    int due;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  go_cnt = 0;
  int  done_cnt = 0;
  int  exp_go = 0;
  int  exp_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write must match the next expected beat, one cycle after its handshake.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("w_addr", 32'(mem_addr), 32'(e.addr));
        check("w_a", 32'(mem_a_wdata), 32'(e.a));
        check("w_b", 32'(mem_b_wdata), 32'(e.b));
        check("w_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (go === 1'b1) begin
      go_cnt++;
      check("go_with_last_write", {23'd0, mem_we, mem_addr}, {23'd0, 1'b1, 8'(N - 1)});
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 none, 1 three idle cycles every 10 beats, 2 random single bubbles.
  // data_mode: 0 {i, ~i}, 1 random. abort_at < 0 disables abort.
  task automatic fill(input int n_beats, input int gap_mode, input int abort_at, input int data_mode);
    logic [15:0] d;
    logic [7:0]  iv;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    for (int idx = 0; idx < n_beats; idx++) begin
      if (gap_mode == 1 && idx > 0 && idx % 10 == 0) begin
        s_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
          check("gap_ready", 32'(s_ready), 32'd1);
          step();
        end
        check("gap_no_write", 32'(mem_we), 32'd0);
      end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        step();
      end
      iv = 8'(idx);
      d  = (data_mode == 0) ? {iv, ~iv} : 16'($urandom);
      s_valid = 1'b1;
      s_data  = d;
      if (idx == abort_at) begin
        load_abort = 1'b1;
        #1;
        check("abort_blocks_ready", 32'(s_ready), 32'd0);
        step();
        load_abort = 1'b0;
        s_valid    = 1'b0;
        return;
      end
      check("fill_ready", 32'(s_ready), 32'd1);
      exp_q.push_back('{addr: idx, a: int'(d[7:0]), b: int'(d[15:8]), due: cyc + 1});
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic expect_kick();
    exp_go++;
    check("kick_go", 32'(go), 32'd1);
    check("kick_busy", 32'(busy), 32'd1);
    check("kick_ready", 32'(s_ready), 32'd0);
    step();
    check("wait_go_low", 32'(go), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_round();
    sad_done = 1'b1;
    step();
    sad_done = 1'b0;
    exp_done++;
    check("done_pulse", 32'(load_done), 32'd1);
    check("done_idle", 32'(busy), 32'd0);
    step();
    check("done_one_cycle", 32'(load_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; load_abort = 1'b0;
    s_valid = 1'b0; s_data = '0; sad_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_go", 32'(go), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", {16'd0, mem_a_wdata, mem_b_wdata}, 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    rst = 1'b0;
    step();

    // Basic back-to-back fill with {i, ~i}
    fill(N, 0, -1, 0);
    expect_kick();
    finish_round();

    // Bubbled stream, random data
    fill(N, 1, -1, 1);
    expect_kick();
    finish_round();

    // Abort on beat 100, then restart from address 0
    fill(N, 2, 100, 1);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_no_write", 32'(mem_we), 32'd0);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);
    check("abort_no_go", 32'(go_cnt), 32'(exp_go));
    fill(N, 2, -1, 1);
    expect_kick();

    // Hold-off: load_req and s_valid held with no sad_done
    load_req = 1'b1;
    s_valid  = 1'b1;
    s_data   = 16'($urandom);
    for (int i = 0; i < 50; i++) begin
      check("hold_ready", 32'(s_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      step();
    end
    sad_done = 1'b1;
    step();
    sad_done = 1'b0;
    load_req = 1'b0;
    s_valid  = 1'b0;
    exp_done++;
    check("hold_done_pulse", 32'(load_done), 32'd1);
    check("hold_done_idle", 32'(busy), 32'd0);
    step();
    check("hold_no_restart", 32'(busy), 32'd0);

    // Reset after beat 40
    fill(40, 2, -1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_go", 32'(go), 32'd0);
    check("midrst_ready", 32'(s_ready), 32'd0);
    repeat (5) step();
    check("midrst_no_go", 32'(go_cnt), 32'(exp_go));

    // Stray sad_done in idle and in fill
    sad_done = 1'b1;
    step();
    sad_done = 1'b0;
    check("stray_idle_busy", 32'(busy), 32'd0);
    check("stray_idle_done", 32'(load_done), 32'd0);
    fill(5, 0, -1, 1);
    sad_done = 1'b1;
    step();
    sad_done = 1'b0;
    check("stray_fill_busy", 32'(busy), 32'd1);
    check("stray_fill_ready", 32'(s_ready), 32'd1);
    check("stray_fill_done", 32'(load_done), 32'd0);
    load_abort = 1'b1;
    step();
    load_abort = 1'b0;
    check("stray_abort_idle", 32'(busy), 32'd0);
    repeat (3) step();

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_go_count", 32'(go_cnt), 32'(exp_go));
    check("final_done_count", 32'(done_cnt), 32'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
